apb_master: RTL and testbench

- APB (AMBA 3) bus master bridging a simple local request interface (transfer, read_write, addresses, write data) onto APB3 signals.
- Runs one transfer at a time through IDLE -> SETUP -> ACCESS, honours pready wait states and returns read data to the local side.
- Sits between a local controller and a single APB slave.
- 4-bit address, 16-bit data.

---
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Purpose  : APB3 bus master. Bridges a simple local request interface
//             (transfer / read_write / address / write data) onto the APB
//             signals, one transfer at a time via IDLE -> SETUP -> ACCESS,
//             honouring pready wait states and returning read data.
//  Ports    :
//     pclk            in   clock, rising edge
//     preset_n        in   synchronous reset, asserted HIGH despite its name
//     pselx/penable   out  APB select / access strobe (decoded from state)
//     paddr/pwrite    out  APB address / direction (1 = write)
//     pwdata          out  APB write data
//     pready/prdata   in   slave ready / read data
//     read_write      in   local request type (1 = write, 0 = read)
//     transfer        in   local request valid
//     apb_read_addr   in   address used for read requests
//     apb_write_addr  in   address used for write requests
//     apb_write_data  in   data used for write requests
//     apb_read_data   out  data of the most recently completed read
//  Revision : 1.0  initial release
// ============================================================================
module apb_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  pclk,
   input  logic                  preset_n,
   output logic                  pselx,
   output logic                  penable,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  read_write,
   input  logic                  transfer,
   input  logic [ADDR_WIDTH-1:0] apb_read_addr,
   input  logic [ADDR_WIDTH-1:0] apb_write_addr,
   input  logic [DATA_WIDTH-1:0] apb_write_data,
   output logic [DATA_WIDTH-1:0] apb_read_data
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    load_req_d;   // entering SETUP: capture local request
   logic                    cap_rd_d;     // read completing: capture prdata
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic                    pwrite_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      load_req_d = 1'b0;
      cap_rd_d   = 1'b0;
      pselx      = 1'b0;
      penable    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               state_d    = ST_SETUP;
               load_req_d = 1'b1;
            end
         end
         ST_SETUP: begin
            pselx   = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            pselx   = 1'b1;
            penable = 1'b1;
            if (pready) begin
               cap_rd_d = ~pwrite_q;
               // A pending request goes straight to SETUP, keeping pselx high
               if (transfer) begin
                  state_d    = ST_SETUP;
                  load_req_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            // Unused encoding: outputs stay inactive, fall back to IDLE
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and request registers
   // ------------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (preset_n) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load_req_d) begin
            pwrite_q <= read_write;
            paddr_q  <= read_write ? apb_write_addr : apb_read_addr;
            // Reads leave the previous write data on the bus
            if (read_write) begin
               pwdata_q <= apb_write_data;
            end
         end
         if (cap_rd_d) begin
            rdata_q <= prdata;
         end
      end
   end

   assign paddr         = paddr_q;
   assign pwrite        = pwrite_q;
   assign pwdata        = pwdata_q;
   assign apb_read_data = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Purpose  : Self-checking bench for apb_master. A transaction-level model
//             tracks the expected bus contents and read data for each request.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_master;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic        pselx, penable, pwrite;
   logic [3:0]  paddr;
   logic [15:0] pwdata;
   logic        pready;
   logic [15:0] prdata;
   logic        read_write, transfer;
   logic [3:0]  apb_read_addr, apb_write_addr;
   logic [15:0] apb_write_data;
   logic [15:0] apb_read_data;

   apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
      .pclk           (pclk),
      .preset_n       (preset_n),
      .pselx          (pselx),
      .penable        (penable),
      .paddr          (paddr),
      .pwrite         (pwrite),
      .pwdata         (pwdata),
      .pready         (pready),
      .prdata         (prdata),
      .read_write     (read_write),
      .transfer       (transfer),
      .apb_read_addr  (apb_read_addr),
      .apb_write_addr (apb_write_addr),
      .apb_write_data (apb_write_data),
      .apb_read_data  (apb_read_data)
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_err = 0;

   // Transaction model: the request presented and what the bus should show
   logic        pend_rw;
   logic [3:0]  pend_wa, pend_ra;
   logic [15:0] pend_wd;
   logic        exp_rw;
   logic [3:0]  exp_addr;
   logic [15:0] exp_pwdata;
   logic [15:0] exp_rdata;
   int          last_access;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic apply_req(input logic rw, input logic [3:0] wa,
                            input logic [3:0] ra, input logic [15:0] wd);
      pend_rw = rw; pend_wa = wa; pend_ra = ra; pend_wd = wd;
      read_write = rw; apb_write_addr = wa; apb_read_addr = ra;
      apb_write_data = wd; transfer = 1'b1;
   endtask

   task automatic apply_rand_req();
      apply_req(1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
   endtask

   // Local inputs other than a pending request are don't-care mid-transfer
   task automatic scramble();
      read_write     = 1'($urandom);
      apb_write_addr = 4'($urandom);
      apb_read_addr  = 4'($urandom);
      apb_write_data = 16'($urandom);
      transfer       = 1'($urandom);
   endtask

   task automatic reset_model();
      exp_rw = 1'b0; exp_addr = 4'h0; exp_pwdata = 16'h0; exp_rdata = 16'h0;
   endtask

   // Called right after the edge that entered SETUP; runs the transfer to
   // completion. chain=1 presents a new request on the completion edge.
   task automatic xfer(input int waits, input logic chain, input logic [15:0] rd);
      exp_rw   = pend_rw;
      exp_addr = pend_rw ? pend_wa : pend_ra;
      if (pend_rw) exp_pwdata = pend_wd;
      n_cmp++;
      if ({pselx, penable, pwrite, paddr, pwdata} !== {2'b10, exp_rw, exp_addr, exp_pwdata}) begin
         n_err++;
         $display("FAIL setup_bus: got sel=%b en=%b wr=%b addr=%h wdata=%h, expected sel=1 en=0 wr=%b addr=%h wdata=%h",
                  pselx, penable, pwrite, paddr, pwdata, exp_rw, exp_addr, exp_pwdata);
      end
      scramble();
      pready = 1'($urandom);   // SETUP must not look at pready
      tick();
      last_access = 0;
      for (int i = 0; i <= waits; i++) begin
         n_cmp++;
         if ({pselx, penable, pwrite, paddr, pwdata} !== {2'b11, exp_rw, exp_addr, exp_pwdata}) begin
            n_err++;
            $display("FAIL access_bus[%0d]: got sel=%b en=%b wr=%b addr=%h wdata=%h, expected sel=1 en=1 wr=%b addr=%h wdata=%h",
                     i, pselx, penable, pwrite, paddr, pwdata, exp_rw, exp_addr, exp_pwdata);
         end
         if (pselx && penable) last_access++;
         if (i < waits) begin
            pready = 1'b0;
            prdata = 16'($urandom);
            scramble();
            tick();
         end
      end
      pready = 1'b1;
      prdata = rd;
      if (chain) apply_rand_req();
      else begin
         scramble();
         transfer = 1'b0;
      end
      tick();
      if (!exp_rw) exp_rdata = rd;
      n_cmp++;
      if (apb_read_data !== exp_rdata) begin
         n_err++;
         $display("FAIL read_data: got %h expected %h", apb_read_data, exp_rdata);
      end
      if (!chain) begin
         n_cmp++;
         if ({pselx, penable} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_after: got sel=%b en=%b expected 0 0", pselx, penable);
         end
      end
      pready = 1'b0;
   endtask

   task automatic test_reset();
      preset_n = 1'b1;
      pready = 1'b1; prdata = 16'hFFFF;
      apply_rand_req();
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if ({pselx, penable, pwrite, paddr, pwdata, apb_read_data} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got sel=%b en=%b wr=%b addr=%h wdata=%h rdata=%h, expected all 0",
                     i, pselx, penable, pwrite, paddr, pwdata, apb_read_data);
         end
      end
      reset_model();
      preset_n = 1'b0;
      transfer = 1'b0;
      pready   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({pselx, penable} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_hold[%0d]: got sel=%b en=%b expected 0 0", i, pselx, penable);
         end
      end
   endtask

   task automatic test_write_wait();
      apply_req(1'b1, 4'hA, 4'h3, 16'hABAB);
      tick();
      xfer(20, 1'b0, 16'h5555);
      n_cmp++;
      if (last_access !== 21) begin
         n_err++;
         $display("FAIL write_access_len: got %0d cycles expected 21", last_access);
      end
   endtask

   task automatic test_read();
      apply_req(1'b0, 4'h2, 4'h4, 16'h1234);
      tick();
      xfer(0, 1'b0, 16'h0066);
      n_cmp++;
      if (apb_read_data !== 16'h0066 || pwdata !== 16'hABAB || paddr !== 4'h4) begin
         n_err++;
         $display("FAIL read_result: got rdata=%h wdata=%h addr=%h expected 0066 ABAB 4",
                  apb_read_data, pwdata, paddr);
      end
   endtask

   task automatic test_back_to_back();
      apply_rand_req();
      tick();
      for (int i = 0; i < 8; i++) xfer(0, i < 7, 16'($urandom));
   endtask

   task automatic test_single();
      for (int k = 0; k < 5; k++) begin
         apply_rand_req();
         tick();
         xfer(int'($urandom_range(0, 4)), 1'b0, 16'($urandom));
         transfer = 1'b0;
         for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
            tick();
            n_cmp++;
            if ({pselx, penable} !== 2'b00 || apb_read_data !== exp_rdata) begin
               n_err++;
               $display("FAIL idle_gap: got sel=%b en=%b rdata=%h expected 0 0 %h",
                        pselx, penable, apb_read_data, exp_rdata);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      // Make read data non-zero first so the reset clearing it is visible
      apply_req(1'b0, 4'h0, 4'h7, 16'h0);
      tick();
      xfer(0, 1'b0, 16'hBEEF);
      apply_req(1'b1, 4'hC, 4'h1, 16'h9999);
      tick();
      pready = 1'b0;
      tick();
      n_cmp++;
      if ({pselx, penable} !== 2'b11) begin
         n_err++;
         $display("FAIL pre_reset_access: got sel=%b en=%b expected 1 1", pselx, penable);
      end
      preset_n = 1'b1;
      tick();
      n_cmp++;
      if ({pselx, penable, pwrite, paddr, pwdata, apb_read_data} !== 35'h0) begin
         n_err++;
         $display("FAIL reset_mid: got sel=%b en=%b wr=%b addr=%h wdata=%h rdata=%h, expected all 0",
                  pselx, penable, pwrite, paddr, pwdata, apb_read_data);
      end
      reset_model();
      preset_n = 1'b0;
      transfer = 1'b0;
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         apply_rand_req();
         tick();
         for (int j = 0; j < 5; j++)
            xfer(int'($urandom_range(0, 3)), (j < 4) && ($urandom_range(0, 3) != 0), 16'($urandom));
         transfer = 1'b0;
         tick();
      end
   endtask

   // xfer exits either idle or already in SETUP; test_random normalises by
   // restarting only after a non-chained tail, so force the last one idle.
   initial begin
      preset_n = 1'b1; transfer = 1'b0; pready = 1'b0; prdata = 16'h0;
      read_write = 1'b0; apb_read_addr = 4'h0; apb_write_addr = 4'h0;
      apb_write_data = 16'h0;
      test_reset();
      test_write_wait();
      test_read();
      test_back_to_back();
      test_single();
      test_reset_mid();
      test_random_safe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Random mix of chained and single transfers; each burst ends non-chained
   task automatic test_random_safe();
      for (int k = 0; k < 6; k++) begin
         int len;
         len = int'($urandom_range(1, 5));
         apply_rand_req();
         tick();
         for (int j = 0; j < len; j++)
            xfer(int'($urandom_range(0, 3)), j < len - 1, 16'($urandom));
         transfer = 1'b0;
         tick();
      end
   endtask

endmodule
`default_nettype wire
